// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter for two requesters sharing one single-port 256x8 RAM.
// Serializes grants onto the RAM port, waits out the read latency, returns a one-cycle ack.
//
//   state | meaning
//   IDLE  | sample a_req/b_req, grant round-robin, latch the winning request
//   ISSUE | drive latched addr/wdata/we onto the RAM for one cycle
//   WAIT  | hold address for RD_LAT cycles until read data is valid
//   DONE  | one-cycle ack to the granted port
module ram_port_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [7:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_ack,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic       b_we,
    input  logic [7:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       b_ack,
    output logic [7:0] b_rdata,
    output logic       busy,
    output logic [7:0] ram_address,
    output logic       ram_write_en,
    output logic [7:0] ram_data_in,
    input  logic [7:0] ram_data_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] WAIT_LOAD = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    state_t     state_q, state_d;
    logic       last_grant_q;   // 1 = port B won the last grant
    logic       grant_valid;
    logic       grant_b;
    logic       capture;
    logic       we_q;
    logic       port_q;         // 1 = current transfer belongs to port B
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [1:0] wait_cnt_q;
    logic [7:0] a_rdata_q;
    logic [7:0] b_rdata_q;

    always_comb begin
        state_d     = state_q;
        grant_valid = 1'b0;
        grant_b     = 1'b0;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_req && b_req) begin
                    grant_valid = 1'b1;
                    grant_b     = ~last_grant_q;
                end else if (a_req) begin
                    grant_valid = 1'b1;
                    grant_b     = 1'b0;
                end else if (b_req) begin
                    grant_valid = 1'b1;
                    grant_b     = 1'b1;
                end
                if (grant_valid) state_d = ISSUE;
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                end else if (RD_LAT == 0) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            port_q       <= 1'b0;
            addr_q       <= 8'h00;
            wdata_q      <= 8'h00;
            wait_cnt_q   <= 2'd0;
            a_rdata_q    <= 8'h00;
            b_rdata_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            if (grant_valid) begin
                last_grant_q <= grant_b;
                port_q       <= grant_b;
                we_q         <= grant_b ? b_we    : a_we;
                addr_q       <= grant_b ? b_addr  : a_addr;
                wdata_q      <= grant_b ? b_wdata : a_wdata;
            end
            // Down-counter loaded on leaving ISSUE; terminal count ends WAIT.
            if (state_q == ISSUE) begin
                wait_cnt_q <= WAIT_LOAD;
            end else if (state_q == WAIT && wait_cnt_q != 2'd0) begin
                wait_cnt_q <= wait_cnt_q - 2'd1;
            end
            if (capture) begin
                if (port_q) b_rdata_q <= ram_data_out;
                else        a_rdata_q <= ram_data_out;
            end
        end
    end

    assign busy         = (state_q != IDLE);
    assign a_ack        = (state_q == DONE) && !port_q;
    assign b_ack        = (state_q == DONE) &&  port_q;
    assign a_rdata      = a_rdata_q;
    assign b_rdata      = b_rdata_q;
    assign ram_address  = addr_q;
    assign ram_data_in  = wdata_q;
    assign ram_write_en = (state_q == ISSUE) && we_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: three instances (RD_LAT 1, 0, 3), each on a behavioral RAM.
// Latency is counted in cycles with the IDLE cycle that sees the request as cycle 0.
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       a_req [3];
    logic       a_we  [3];
    logic [7:0] a_addr [3];
    logic [7:0] a_wdata [3];
    logic       b_req [3];
    logic       b_we  [3];
    logic [7:0] b_addr [3];
    logic [7:0] b_wdata [3];
    logic       a_ack [3];
    logic       b_ack [3];
    logic [7:0] a_rdata [3];
    logic [7:0] b_rdata [3];
    logic       busy [3];
    logic       ram_we [3];
    logic [7:0] ram_addr [3];
    logic [7:0] ram_din [3];
    logic [7:0] ram_dout [3];

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        logic [7:0] mem [256];
        logic [7:0] pipe [4];

        always @(posedge clk) begin
            if (ram_we[g]) mem[ram_addr[g]] <= ram_din[g];
            pipe[0] <= mem[ram_addr[g]];
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign ram_dout[g] = (L == 0) ? mem[ram_addr[g]] : pipe[(L == 0) ? 0 : L - 1];

        ram_port_arbiter #(.RD_LAT(L)) u_dut (
            .clk(clk), .reset(reset),
            .a_req(a_req[g]), .a_we(a_we[g]), .a_addr(a_addr[g]), .a_wdata(a_wdata[g]),
            .a_ack(a_ack[g]), .a_rdata(a_rdata[g]),
            .b_req(b_req[g]), .b_we(b_we[g]), .b_addr(b_addr[g]), .b_wdata(b_wdata[g]),
            .b_ack(b_ack[g]), .b_rdata(b_rdata[g]),
            .busy(busy[g]),
            .ram_address(ram_addr[g]), .ram_write_en(ram_we[g]),
            .ram_data_in(ram_din[g]), .ram_data_out(ram_dout[g])
        );
    end

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 3; d++) begin
            a_req[d] = 1'b0; a_we[d] = 1'b0; a_addr[d] = 8'h00; a_wdata[d] = 8'h00;
            b_req[d] = 1'b0; b_we[d] = 1'b0; b_addr[d] = 8'h00; b_wdata[d] = 8'h00;
        end
    endtask

    // One transfer on instance d; port 0 = A, 1 = B. Starts in an IDLE cycle.
    task automatic xfer(input int d, input bit port, input bit we, input logic [7:0] addr,
                        input logic [7:0] wdata, input bit scramble,
                        output int lat, output logic [7:0] rdata,
                        output int we_cycles, output int other_acks);
        lat = -1; rdata = 8'h00; we_cycles = 0; other_acks = 0;
        @(negedge clk);
        if (!port) begin
            a_req[d] = 1'b1; a_we[d] = we; a_addr[d] = addr; a_wdata[d] = wdata;
        end else begin
            b_req[d] = 1'b1; b_we[d] = we; b_addr[d] = addr; b_wdata[d] = wdata;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ram_we[d]) we_cycles++;
            if (scramble && c == 1) begin
                if (!port) begin a_addr[d] = addr ^ 8'h01; a_wdata[d] = ~wdata; end
                else       begin b_addr[d] = addr ^ 8'h01; b_wdata[d] = ~wdata; end
                #1;
                check_val("hold_addr", ram_addr[d], addr);
                check_val("hold_wdata", ram_din[d], wdata);
            end
            if (port ? a_ack[d] : b_ack[d]) other_acks++;
            if (port ? b_ack[d] : a_ack[d]) begin
                lat   = c;
                rdata = port ? b_rdata[d] : a_rdata[d];
                break;
            end
        end
        a_req[d] = 1'b0;
        b_req[d] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wec, oth, a_cyc, b_cyc, n_acks;
        logic [7:0] rd, b_rd;
        int seq [6];

        clear_inputs();
        reset = 1'b0;

        // Reset held with random inputs
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                a_req[d] = 1'($urandom); a_we[d] = 1'($urandom);
                a_addr[d] = 8'($urandom); a_wdata[d] = 8'($urandom);
                b_req[d] = 1'($urandom); b_we[d] = 1'($urandom);
                b_addr[d] = 8'($urandom); b_wdata[d] = 8'($urandom);
            end
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            check_val($sformatf("rst_ctl%0d", d), int'({a_ack[d], b_ack[d], busy[d], ram_we[d]}), 0);
            check_val($sformatf("rst_data%0d", d),
                      int'(a_rdata[d] | b_rdata[d] | ram_addr[d] | ram_din[d]), 0);
        end
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;

        // Write then read-back, RD_LAT=1
        xfer(0, 0, 1, 8'h01, 8'h01, 0, lat, rd, wec, oth);
        check_val("wr_lat", lat, 2);
        check_val("wr_we_cycles", wec, 1);
        check_val("wr_other_ack", oth, 0);
        xfer(0, 1, 0, 8'h01, 8'h00, 0, lat, rd, wec, oth);
        check_val("rd_lat", lat, 3);
        check_val("rd_data", rd, 8'h01);
        check_val("rd_we_cycles", wec, 0);
        check_val("rd_other_ack", oth, 0);

        // Contention right after reset: A write wins, B read sees new data
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 8'h10; a_wdata[0] = 8'hAA;
        b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 8'h10;
        a_cyc = -1; b_cyc = -1; b_rd = 8'h00;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (a_ack[0] && a_cyc < 0) begin a_cyc = c; a_req[0] = 1'b0; end
            if (b_ack[0] && b_cyc < 0) begin b_cyc = c; b_rd = b_rdata[0]; b_req[0] = 1'b0; end
            if (a_cyc > 0 && b_cyc > 0) break;
        end
        check_val("cont_a_cycle", a_cyc, 2);
        check_val("cont_b_cycle", b_cyc, 6);
        check_val("cont_b_data", b_rd, 8'hAA);

        // Both held high: strict A,B,A,B alternation
        @(negedge clk);
        a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 8'h10;
        b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 8'h01;
        n_acks = 0;
        for (int c = 0; c < 60 && n_acks < 6; c++) begin
            @(negedge clk);
            if (a_ack[0] && b_ack[0]) begin
                seq[n_acks] = 2; n_acks++;
            end else if (a_ack[0]) begin
                check_val("alt_a_data", a_rdata[0], 8'hAA);
                seq[n_acks] = 0; n_acks++;
            end else if (b_ack[0]) begin
                check_val("alt_b_data", b_rdata[0], 8'h01);
                seq[n_acks] = 1; n_acks++;
            end
        end
        a_req[0] = 1'b0; b_req[0] = 1'b0;
        check_val("alt_count", n_acks, 6);
        for (int k = 0; k < n_acks; k++) check_val($sformatf("alt_order%0d", k), seq[k], k % 2);

        // Requester inputs change after the grant edge
        xfer(0, 0, 1, 8'h21, 8'h99, 0, lat, rd, wec, oth);
        xfer(0, 0, 1, 8'h20, 8'h55, 1, lat, rd, wec, oth);
        check_val("scr_lat", lat, 2);
        xfer(0, 1, 0, 8'h20, 8'h00, 0, lat, rd, wec, oth);
        check_val("scr_rd20", rd, 8'h55);
        xfer(0, 0, 0, 8'h21, 8'h00, 0, lat, rd, wec, oth);
        check_val("scr_rd21", rd, 8'h99);

        // Reset during WAIT of a read
        @(negedge clk);
        b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 8'h10;
        @(negedge clk);
        @(negedge clk);
        check_val("midrd_busy_before", busy[0], 1);
        reset = 1'b0;
        b_req[0] = 1'b0;
        #1;
        check_val("midrd_busy_after", busy[0], 0);
        check_val("midrd_rdata_cleared", b_rdata[0], 8'h00);
        oth = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_ack[0] || b_ack[0]) oth++;
        end
        check_val("midrd_no_ack", oth, 0);
        reset = 1'b1;
        xfer(0, 1, 0, 8'h10, 8'h00, 0, lat, rd, wec, oth);
        check_val("midrd_new_lat", lat, 3);
        check_val("midrd_new_data", rd, 8'hAA);

        // Reset during ISSUE of a write drops ram_write_en without a clock
        @(negedge clk);
        a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 8'h30; a_wdata[0] = 8'h77;
        @(negedge clk);
        check_val("midwr_we_before", ram_we[0], 1);
        reset = 1'b0;
        a_req[0] = 1'b0;
        #1;
        check_val("midwr_we_after", ram_we[0], 0);
        @(negedge clk);
        reset = 1'b1;

        // RD_LAT = 0
        xfer(1, 0, 1, 8'h05, 8'h3C, 0, lat, rd, wec, oth);
        check_val("l0_wr_lat", lat, 2);
        xfer(1, 1, 0, 8'h05, 8'h00, 0, lat, rd, wec, oth);
        check_val("l0_rd_lat", lat, 2);
        check_val("l0_rd_data", rd, 8'h3C);

        // RD_LAT = 3, plus rdata hold across a write on the same port
        xfer(2, 0, 1, 8'h07, 8'hC3, 0, lat, rd, wec, oth);
        check_val("l3_wr_lat", lat, 2);
        check_val("l3_wr_we_cycles", wec, 1);
        xfer(2, 1, 0, 8'h07, 8'h00, 0, lat, rd, wec, oth);
        check_val("l3_rd_lat", lat, 5);
        check_val("l3_rd_data", rd, 8'hC3);
        xfer(2, 1, 1, 8'h08, 8'h11, 0, lat, rd, wec, oth);
        check_val("l3_b_wr_lat", lat, 2);
        check_val("l3_rdata_hold", b_rdata[2], 8'hC3);
        xfer(2, 0, 0, 8'h08, 8'h00, 0, lat, rd, wec, oth);
        check_val("l3_a_rd_lat", lat, 5);
        check_val("l3_a_rd_data", rd, 8'h11);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
